// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Framed byte-stream program loader for the SAP-2 RAM write port.
//            Holds the CPU in reset until a checksum-verified frame commits.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sum;
    logic [8:0]            remaining;
    logic [ADDR_WIDTH-1:0] ptr;

    logic                  accept;
    logic                  is_sync;
    logic [DATA_WIDTH-1:0] sum_next;

    assign accept   = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign sum_next = sum + in_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sum       <= '0;
            remaining <= '0;
            ptr       <= '0;
            in_ready  <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            ram_we   <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (is_sync) begin
                            sum       <= '0;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            state     <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        // A zero length field encodes a full 256-byte payload
                        remaining <= (in_data == '0) ? 9'd256 : 9'(in_data);
                        sum       <= sum_next;
                        state     <= ST_ADDR;
                    end
                    ST_ADDR: begin
                        ptr   <= in_data[ADDR_WIDTH-1:0];
                        sum   <= sum_next;
                        state <= ST_DATA;
                    end
                    ST_DATA: begin
                        ram_we    <= 1'b1;
                        ram_addr  <= ptr;
                        ram_wdata <= in_data;
                        ptr       <= ptr + ADDR_WIDTH'(1);
                        sum       <= sum_next;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (sum_next == '0) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            load_err <= 1'b1;
                            state    <= ST_ERR;
                        end
                    end
                    ST_DONE, ST_ERR: begin
                        // Only a fresh SYNC restarts; everything else is dropped
                        if (is_sync) begin
                            sum       <= '0;
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            state     <= ST_LEN;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Scoreboard bench for prog_loader frame loading and RAM writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    prog_loader #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_we     = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  mem[256];
    logic [7:0]  pl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe pops the next expected {addr,data}
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            n_we++;
            mem[ram_addr] = ram_wdata;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h required none", ram_addr, ram_wdata);
            end else begin
                check("ram_write", {16'h0, ram_addr, ram_wdata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; returns 1 unit after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", {31'h0, in_ready}, 32'h1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] addr,
                              input logic [7:0] csum_adj, input bit throttle,
                              input bit check_sync);
        logic [7:0] s;
        s = len + addr;
        send_byte(8'hA5, throttle ? int'($urandom_range(0, 2)) : 0);
        if (check_sync) begin
            check("reload_hold_rises", {31'h0, cpu_hold}, 32'h1);
            check("reload_done_clears", {31'h0, load_done}, 32'h0);
        end
        send_byte(len, throttle ? int'($urandom_range(0, 2)) : 0);
        send_byte(addr, throttle ? int'($urandom_range(0, 2)) : 0);
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({addr + 8'(i), pl[i]});
            s = s + pl[i];
            send_byte(pl[i], throttle ? int'($urandom_range(0, 2)) : 0);
        end
        send_byte((8'h00 - s) + csum_adj, throttle ? int'($urandom_range(0, 2)) : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold_low;
        int we_base;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        pl = '{8'h1E, 8'h2F, 8'h3E, 8'h0C, 8'h9D, 8'h53, 8'h7A, 8'hF0,
               8'h01, 8'h0D, 8'h03, 8'h07, 8'hA5, 8'h00, 8'h02, 8'hFF};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_cpu_hold", {31'h0, cpu_hold}, 32'h1);
        check("rst_ram_we", {31'h0, ram_we}, 32'h0);
        check("rst_ram_addr", {24'h0, ram_addr}, 32'h0);
        check("rst_ram_wdata", {24'h0, ram_wdata}, 32'h0);
        check("rst_load_done", {31'h0, load_done}, 32'h0);
        check("rst_load_err", {31'h0, load_err}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", {31'h0, in_ready}, 32'h1);

        // Program load: 16 bytes at 0x00, good checksum
        we_base = n_we;
        send_frame(8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
        check("prog_done", {31'h0, load_done}, 32'h1);
        check("prog_err", {31'h0, load_err}, 32'h0);
        check("prog_hold", {31'h0, cpu_hold}, 32'h0);
        check("prog_writes_drained", exp_q.size(), 32'h0);
        check("prog_we_pulses", n_we - we_base, 32'd16);

        // Same frame, checksum off by one
        send_frame(8'h10, 8'h00, 8'h01, 1'b0, 1'b0);
        check("bad_err", {31'h0, load_err}, 32'h1);
        check("bad_done", {31'h0, load_done}, 32'h0);
        check("bad_hold", {31'h0, cpu_hold}, 32'h1);
        hold_low = 0;
        repeat (200) begin
            @(negedge clk);
            if (cpu_hold !== 1'b1) hold_low++;
        end
        check("bad_never_released", hold_low, 32'h0);
        @(posedge clk);
        #1;

        // Wrap and embedded sync: 03+FE+A5+11+22 = 0xD9, so CSUM = 0x27
        exp_q.push_back(16'hFE_A5);
        exp_q.push_back(16'hFF_11);
        exp_q.push_back(16'h00_22);
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h27, 0);
        check("wrap_done", {31'h0, load_done}, 32'h1);
        check("wrap_hold", {31'h0, cpu_hold}, 32'h0);
        check("wrap_mem_fe", {24'h0, mem[8'hFE]}, 32'hA5);
        check("wrap_mem_ff", {24'h0, mem[8'hFF]}, 32'h11);
        check("wrap_mem_00", {24'h0, mem[8'h00]}, 32'h22);

        // Leading garbage is ignored, then a throttled frame at 0x20
        send_byte(8'h00, 1);
        send_byte(8'h5A, 2);
        check("garbage_done_kept", {31'h0, load_done}, 32'h1);
        check("garbage_hold_kept", {31'h0, cpu_hold}, 32'h0);
        send_frame(8'h10, 8'h20, 8'h00, 1'b1, 1'b0);
        check("throttle_done", {31'h0, load_done}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            check("throttle_mem", {16'h0, 8'(i), mem[8'h20 + 8'(i)]}, {16'h0, 8'(i), pl[i]});
        end

        // Reset after 5 payload bytes of a 16-byte frame at 0x40
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        send_byte(8'h40, 0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({8'h40 + 8'(i), pl[i]});
            send_byte(pl[i], 0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_hold", {31'h0, cpu_hold}, 32'h1);
        check("midrst_we", {31'h0, ram_we}, 32'h0);
        check("midrst_addr", {24'h0, ram_addr}, 32'h0);
        check("midrst_done", {31'h0, load_done}, 32'h0);
        check("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("midrst_kept", {16'h0, 8'(i), mem[8'h40 + 8'(i)]}, {16'h0, 8'(i), pl[i]});
        end
        check("midrst_not_written", {24'h0, mem[8'h45]}, 32'h0);
        send_frame(8'h10, 8'h60, 8'h00, 1'b0, 1'b0);
        check("after_rst_done", {31'h0, load_done}, 32'h1);
        check("after_rst_hold", {31'h0, cpu_hold}, 32'h0);

        // Reload from DONE: hold rises on the SYNC edge
        send_frame(8'h04, 8'h80, 8'h00, 1'b0, 1'b1);
        check("reload_done", {31'h0, load_done}, 32'h1);
        check("reload_hold", {31'h0, cpu_hold}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("all_writes_seen", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
